seg7_scan_ctrl: RTL and testbench

Time-multiplexed scan controller that shares the smallCALC BCD-to-7-segment decoder across four display digits. It holds a tear-free shadow copy of the four BCD digits and steps through them, one digit slot at a time. For each slot it drives the shared decoder's BCD input and the active-low digit anodes, with a dark guard interval between digits to suppress ghosting. It sits between the calculator result/operand logic and the board's 4-digit common-anode display.

---
 rtl/seg7_scan_ctrl.sv | 113 +++++++++++
 tb/tb_seg7_scan_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan controller for a 4-digit
// common-anode display that shares one BCD-to-7-segment decoder.
// The four BCD digits are held in a shadow register that changes only at
// a frame boundary, or while the display is dark, so no frame mixes old
// and new digits. Each digit slot starts with a dark guard interval.
// Optional feature: define SEG7_LZB_EN to enable leading-zero blanking
// on digits 1..3.
module seg7_scan_ctrl #(
  parameter int REFRESH_DIV = 1024,
  parameter int GUARD_CYC   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] digits_in,
  output logic        upd_done,
  output logic [3:0]  bcd_out,
  output logic [3:0]  anode
);

  localparam int               CNT_W   = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD   = CNT_W'(GUARD_CYC);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [15:0]      pend;
  logic [15:0]      shd;
  logic             pflag;
  logic             wrap;
  logic             frame_end;
  logic             lz_dark;

  assign wrap      = (cnt == CNT_MAX);
  assign frame_end = wrap && (idx == 2'd3);

`ifdef SEG7_LZB_EN
  // A digit above digit 0 goes dark when it and every more-significant
  // digit are zero; digit 0 always shows.
  function automatic logic lz_blank(input logic [15:0] s, input logic [1:0] k);
    logic b;
    case (k)
      2'd1:    b = (s[15:4] == 12'h000);
      2'd2:    b = (s[15:8] == 8'h00);
      2'd3:    b = (s[15:12] == 4'h0);
      default: b = 1'b0;
    endcase
    return b;
  endfunction

  assign lz_dark = lz_blank(shd, idx);
`else
  assign lz_dark = 1'b0;
`endif

  // Slot counter and digit index; disabled scanning parks at digit 0, cycle 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (!en) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (wrap) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Load capture and shadow transfer; shd only moves at the frame boundary
  // or while the display is dark, and upd_done marks the cycle after.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend     <= 16'h0000;
      pflag    <= 1'b0;
      shd      <= 16'h0000;
      upd_done <= 1'b0;
    end else begin
      upd_done <= 1'b0;
      if (load && en && frame_end) begin
        shd      <= digits_in;
        pend     <= digits_in;
        pflag    <= 1'b0;
        upd_done <= 1'b1;
      end else if (load) begin
        pend  <= digits_in;
        pflag <= 1'b1;
      end else if (pflag && (!en || frame_end)) begin
        shd      <= pend;
        pflag    <= 1'b0;
        upd_done <= 1'b1;
      end
    end
  end

  // Registered anode/BCD drive from the current slot position.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      anode   <= 4'b1111;
      bcd_out <= 4'hF;
    end else if (!en || (cnt < GUARD) || lz_dark) begin
      anode   <= 4'b1111;
      bcd_out <= 4'hF;
    end else begin
      anode   <= ~(4'b0001 << idx);
      bcd_out <= shd[{idx, 2'b00} +: 4];
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: directed scenarios plus random traffic, checked
// every cycle against a frame-position reference model.
module tb_seg7_scan_ctrl;

  localparam int RD    = 8;
  localparam int G     = 2;
  localparam int FRAME = 4 * RD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits_in = 16'h0000;
  logic        upd_done;
  logic [3:0]  bcd_out;
  logic [3:0]  anode;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.REFRESH_DIV(RD), .GUARD_CYC(G)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .load      (load),
    .digits_in (digits_in),
    .upd_done  (upd_done),
    .bcd_out   (bcd_out),
    .anode     (anode)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_upd    = 0;

  // Reference model: position within the frame plus the displayed,
  // pending and flag contents.
  int          m_t = 0;
  logic [15:0] m_shd = 16'h0000;
  logic [15:0] m_pend = 16'h0000;
  bit          m_pf = 1'b0;
  logic [3:0]  exp_anode;
  logic [3:0]  exp_bcd;
  logic        exp_upd;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic e, input logic l, input logic [15:0] d);
    int k;
    int off;
    bit dark;
    bit boundary;
    k = m_t / RD;
    off = m_t % RD;
    exp_upd = 1'b0;
    if (!r) begin
      exp_anode = 4'hF;
      exp_bcd   = 4'hF;
      m_t = 0;
      m_shd = 16'h0000;
      m_pend = 16'h0000;
      m_pf = 1'b0;
    end else begin
      dark = !e || (off < G);
`ifdef SEG7_LZB_EN
      if (k > 0 && (m_shd >> (4 * k)) == 16'h0000) dark = 1'b1;
`endif
      if (dark) begin
        exp_anode = 4'hF;
        exp_bcd   = 4'hF;
      end else begin
        exp_anode = ~(4'b0001 << k);
        exp_bcd   = m_shd[4*k +: 4];
      end
      if (e) begin
        boundary = (m_t == FRAME - 1);
        if (l && boundary) begin
          m_shd = d; m_pf = 1'b0; exp_upd = 1'b1;
        end else if (l) begin
          m_pend = d; m_pf = 1'b1;
        end else if (boundary && m_pf) begin
          m_shd = m_pend; m_pf = 1'b0; exp_upd = 1'b1;
        end
        m_t = (m_t + 1) % FRAME;
      end else begin
        m_t = 0;
        if (l) begin
          m_pend = d; m_pf = 1'b1;
        end else if (m_pf) begin
          m_shd = m_pend; m_pf = 1'b0; exp_upd = 1'b1;
        end
      end
    end
  endtask

  // One clock: drive inputs on the falling edge, compare just after the rise.
  task automatic tick(input logic r, input logic e, input logic l, input logic [15:0] d);
    @(negedge clk);
    rst_n = r;
    en = e;
    load = l;
    digits_in = d;
    model_step(r, e, l, d);
    @(posedge clk);
    #1;
    check("anode", {12'h000, anode}, {12'h000, exp_anode});
    check("bcd_out", {12'h000, bcd_out}, {12'h000, exp_bcd});
    check("upd_done", {15'h0000, upd_done}, {15'h0000, exp_upd});
    if (upd_done === 1'b1) n_upd++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b1, 1'b0, 16'($urandom));
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < FRAME && m_t != target; i++) tick(1'b1, 1'b1, 1'b0, 16'($urandom));
    check("run_to_pos", 16'(m_t), 16'(target));
  endtask

  initial begin
    int upd_before;
    logic r, e, l;
    logic [15:0] d;

    // Reset, then free-running scan of zeros.
    tick(1'b0, 1'b0, 1'b0, 16'hFFFF);
    tick(1'b0, 1'b1, 1'b0, 16'hFFFF);
    run(4 * FRAME);

    // Tear-free load in the middle of the digit 1 slot.
    run_to(RD + 4);
    upd_before = n_upd;
    tick(1'b1, 1'b1, 1'b1, 16'h1234);
    run(2 * FRAME);
    check("one_upd_1234", 16'(n_upd - upd_before), 16'd1);

    // Back-to-back loads before the boundary give one update.
    run_to(5);
    upd_before = n_upd;
    tick(1'b1, 1'b1, 1'b1, 16'h1111);
    run(3);
    tick(1'b1, 1'b1, 1'b1, 16'h9876);
    run(2 * FRAME);
    check("one_upd_9876", 16'(n_upd - upd_before), 16'd1);

    // Load on the boundary cycle itself.
    run_to(FRAME - 1);
    upd_before = n_upd;
    tick(1'b1, 1'b1, 1'b1, 16'h4321);
    run(FRAME + 3);
    check("one_upd_coinc", 16'(n_upd - upd_before), 16'd1);

    // Enable drop mid digit 2, a load with en low, then resume.
    run_to(2 * RD + 4);
    tick(1'b1, 1'b0, 1'b1, 16'h0507);
    tick(1'b1, 1'b0, 1'b0, 16'hAAAA);
    tick(1'b1, 1'b0, 1'b0, 16'hAAAA);
    run(FRAME + 4);

    // Reset while a load is pending discards it.
    run_to(6);
    upd_before = n_upd;
    tick(1'b1, 1'b1, 1'b1, 16'h8888);
    tick(1'b0, 1'b1, 1'b0, 16'h0000);
    run(2 * FRAME);
    check("no_upd_after_rst", 16'(n_upd - upd_before), 16'd0);

    // Leading zeros, with and without blanking.
    tick(1'b1, 1'b1, 1'b1, 16'h0050);
    run(2 * FRAME);
    tick(1'b1, 1'b1, 1'b1, 16'h0000);
    run(2 * FRAME);
    tick(1'b1, 1'b1, 1'b1, 16'h00F3);
    run(2 * FRAME);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(0, 299) != 0);
      e = ($urandom_range(0, 24) != 0);
      l = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0:       d = 16'h0000;
        1:       d = {8'h00, 8'($urandom)};
        2:       d = {4'h0, 12'($urandom)};
        default: d = 16'($urandom);
      endcase
      tick(r, e, l, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
